// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serialises independent read/write requests from NUM_PORTS requesters
//   onto one single-ported synchronous memory whose read data arrives
//   MEM_LATENCY cycles after the access strobe. Winners are picked
//   round-robin. A port with both a read and a write pending is served
//   write first.
//
// Handshake: a requester holds req_read/req_write (with address and data)
//   as a level. The block answers with a one-cycle req_*_ready pulse. The
//   requester must drop or replace the request in the cycle after the
//   pulse, because a request still present in the following IDLE cycle is
//   granted again as a new one. Address/data are sampled only at grant.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_read/_address     per-port read request and address (packed buses)
//   req_write/_address/_value  per-port write request, address, data
//   req_read_ready/_value per-port read completion pulse and held data
//   req_write_ready       per-port write commit pulse
//   mem_en/_we/_addr/_wdata  memory command (all registered)
//   mem_rdata             memory read data
//   dbg_state             current FSM state (IDLE=0 ACCESS=1 WAIT=2 DONE=3)
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_PORTS   = 2,
   parameter int MEM_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             req_read,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_read_address,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_write_address,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_write_value,
   output logic [NUM_PORTS-1:0]             req_read_ready,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  req_read_value,
   output logic [NUM_PORTS-1:0]             req_write_ready,
   output logic                             mem_en,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [DATA_WIDTH-1:0]            mem_wdata,
   input  logic [DATA_WIDTH-1:0]            mem_rdata,
   output logic [1:0]                       dbg_state
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          grant_q, grant_d;
   logic [PW-1:0]          last_q, last_d;
   logic                   op_we_q, op_we_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic [NUM_PORTS-1:0]   rready_q, rready_d;
   logic [NUM_PORTS-1:0]   wready_q, wready_d;
   logic [DATA_WIDTH-1:0]  rval_q [NUM_PORTS];
   logic [DATA_WIDTH-1:0]  rval_d [NUM_PORTS];

   // Unpacked views of the per-port buses
   logic [ADDR_WIDTH-1:0]  rd_addr_a [NUM_PORTS];
   logic [ADDR_WIDTH-1:0]  wr_addr_a [NUM_PORTS];
   logic [DATA_WIDTH-1:0]  wr_val_a  [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign rd_addr_a[p] = req_read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_addr_a[p] = req_write_address[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign wr_val_a[p]  = req_write_value[p*DATA_WIDTH +: DATA_WIDTH];
      assign req_read_value[p*DATA_WIDTH +: DATA_WIDTH] = rval_q[p];
   end

   // Round-robin search: first pending port after last_q, wrapping.
   logic [NUM_PORTS-1:0]   pending;
   logic [PW-1:0]          idx;
   logic [PW-1:0]          win;
   logic                   found;

   always_comb begin
      pending = req_read | req_write;
      idx     = '0;
      win     = '0;
      found   = 1'b0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = PW'((int'(last_q) + i) % NUM_PORTS);
         if (!found && pending[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      op_we_d     = op_we_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rready_d    = '0;
      wready_d    = '0;
      rval_d      = rval_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d     = win;
               last_d      = win;
               op_we_d     = req_write[win];
               mem_addr_d  = req_write[win] ? wr_addr_a[win] : rd_addr_a[win];
               mem_wdata_d = wr_val_a[win];
               // Strobe and write pulse are registered so they appear
               // together in the ACCESS cycle.
               mem_en_d       = 1'b1;
               mem_we_d       = req_write[win];
               wready_d[win]  = req_write[win];
               state_d        = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (op_we_q) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = CW'(MEM_LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // The last WAIT cycle is the one in which mem_rdata is valid.
            if (cnt_q == '0) begin
               rval_d[grant_q]   = mem_rdata;
               rready_d[grant_q] = 1'b1;
               state_d           = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         last_q      <= PW'(NUM_PORTS - 1);
         op_we_q     <= 1'b0;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rready_q    <= '0;
         wready_q    <= '0;
         for (int p = 0; p < NUM_PORTS; p++) rval_q[p] <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         op_we_q     <= op_we_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rready_q    <= rready_d;
         wready_q    <= wready_d;
         for (int p = 0; p < NUM_PORTS; p++) rval_q[p] <= rval_d[p];
      end
   end

   assign req_read_ready  = rready_q;
   assign req_write_ready = wready_q;
   assign mem_en          = mem_en_q;
   assign mem_we          = mem_we_q;
   assign mem_addr        = mem_addr_q;
   assign mem_wdata       = mem_wdata_q;
   assign dbg_state       = state_q;

endmodule
